// File: rtl/sobel_frame_controller.sv
// sobel_frame_controller
// Sequences one binary Sobel frame: clears the filter, feeds PX_PER_ROW*ROWS
// upstream pixels, waits out the window/pipeline warm-up, flushes the tail
// with zero pixels and emits exactly one out_valid strobe per pixel with its
// window-centre coordinates.
// Optional build macro SOBEL_BORDER_MASK_EN: when defined, out_px is forced
// to 0 on the outermost row/column ring, where the 3x3 window is incomplete.
module sobel_frame_controller #(
    parameter logic [15:0] PX_PER_ROW = 16'd520,
    parameter logic [15:0] ROWS       = 16'd390,
    parameter logic [15:0] PIPE_LAT   = 16'd2
) (
    input  logic        CLK100MHZ,
    input  logic        btn_reset,
    input  logic        start,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic        filter_px,
    output logic        filter_ena,
    output logic        filter_clr,
    output logic        flush_sel,
    output logic        out_valid,
    output logic        out_px,
    output logic [11:0] out_col,
    output logic [11:0] out_row,
    output logic        busy,
    output logic        frame_done
);

    // Transfers needed before the filter output lines up with window (0,0).
    localparam logic [15:0] WARM      = PX_PER_ROW + 16'd1 + PIPE_LAT;
    localparam logic [15:0] WARM_LAST = WARM - 16'd1;
    localparam logic [15:0] LAST_COL  = PX_PER_ROW - 16'd1;
    localparam logic [15:0] LAST_ROW  = ROWS - 16'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] in_col_r;
    logic [15:0] in_row_r;
    logic [15:0] out_col_cnt_r;
    logic [15:0] out_row_cnt_r;
    logic [15:0] warm_cnt_r;
    logic        accept_s;
    logic        emit_s;
    logic        in_last_s;
    logic        out_last_s;
    logic        warm_hit_s;
    logic        px_mask_s;
    logic        out_valid_r;
    logic        out_px_r;
    logic [11:0] out_col_r;
    logic [11:0] out_row_r;

    assign in_last_s  = (in_row_r == LAST_ROW) && (in_col_r == LAST_COL);
    assign out_last_s = (out_row_cnt_r == LAST_ROW) && (out_col_cnt_r == LAST_COL);
    assign warm_hit_s = (warm_cnt_r == WARM_LAST);

`ifdef SOBEL_BORDER_MASK_EN
    // True on the outer ring where the 3x3 window reaches outside the image.
    function automatic logic on_border(input logic [15:0] row, input logic [15:0] col);
        return (row == 16'd0) || (row == LAST_ROW) || (col == 16'd0) || (col == LAST_COL);
    endfunction

    assign px_mask_s = filter_px & ~on_border(out_row_cnt_r, out_col_cnt_r);
`else
    assign px_mask_s = filter_px;
`endif

    // Next-state and state-decoded control strobes.
    always_comb begin
        state_nxt_s = state_r;
        px_ready    = 1'b0;
        filter_ena  = 1'b0;
        filter_clr  = 1'b0;
        flush_sel   = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        accept_s    = 1'b0;
        emit_s      = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                filter_clr  = 1'b1;
                state_nxt_s = FILL;
            end
            FILL: begin
                px_ready   = 1'b1;
                filter_ena = px_valid;
                accept_s   = px_valid;
                if (px_valid && in_last_s) begin
                    state_nxt_s = FLUSH;
                end else if (px_valid && warm_hit_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            RUN: begin
                px_ready   = 1'b1;
                filter_ena = px_valid;
                accept_s   = px_valid;
                emit_s     = px_valid;
                if (px_valid && in_last_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                flush_sel  = 1'b1;
                filter_ena = 1'b1;
                emit_s     = 1'b1;
                if (out_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            DONE: begin
                frame_done  = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                busy        = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK100MHZ) begin
        if (btn_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Input, warm-up and output raster counters; all hold while stalled.
    always_ff @(posedge CLK100MHZ) begin
        if (btn_reset || (state_r == CLEAR)) begin
            in_col_r      <= 16'd0;
            in_row_r      <= 16'd0;
            out_col_cnt_r <= 16'd0;
            out_row_cnt_r <= 16'd0;
            warm_cnt_r    <= 16'd0;
        end else begin
            if (accept_s) begin
                if (in_col_r == LAST_COL) begin
                    in_col_r <= 16'd0;
                    in_row_r <= in_row_r + 16'd1;
                end else begin
                    in_col_r <= in_col_r + 16'd1;
                end
                if (warm_cnt_r != WARM) begin
                    warm_cnt_r <= warm_cnt_r + 16'd1;
                end
            end
            if (emit_s) begin
                if (out_col_cnt_r == LAST_COL) begin
                    out_col_cnt_r <= 16'd0;
                    out_row_cnt_r <= out_row_cnt_r + 16'd1;
                end else begin
                    out_col_cnt_r <= out_col_cnt_r + 16'd1;
                end
            end
        end
    end

    // Registered output pixel strobe; fields are zero whenever no pixel is emitted.
    always_ff @(posedge CLK100MHZ) begin
        if (btn_reset) begin
            out_valid_r <= 1'b0;
            out_px_r    <= 1'b0;
            out_col_r   <= 12'd0;
            out_row_r   <= 12'd0;
        end else begin
            out_valid_r <= emit_s;
            out_px_r    <= emit_s & px_mask_s;
            out_col_r   <= emit_s ? out_col_cnt_r[11:0] : 12'd0;
            out_row_r   <= emit_s ? out_row_cnt_r[11:0] : 12'd0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_px    = out_px_r;
    assign out_col   = out_col_r;
    assign out_row   = out_row_r;

endmodule
